// File: rtl/counter_mod_updown.sv
// Modulo up/down counter with prescaler, wrap/saturate mode,
// synchronous clear/load and a registered boundary-step pulse.
module counter_mod_updown #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter bit     SATURATE = 1'b0,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             limit
);

  localparam int CW = WIDTH + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CW-1:0] MODV = CW'(MODULUS);
  localparam logic [CW-1:0] MAXV = CW'(MODULUS - 1);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  if (MODULUS > (64'd1 << WIDTH)) begin : g_bad_mod_hi
    $error("MODULUS exceeds 2**WIDTH");
  end
  if (MODULUS < 2) begin : g_bad_mod_lo
    $error("MODULUS below 2");
  end
  if (PRESCALE < 1) begin : g_bad_pre
    $error("PRESCALE below 1");
  end

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             lim_q, lim_d;
  logic [CW-1:0]    cnt_x, ld_x;

  // Widened views keep MODULUS == 2**WIDTH free of overflow.
  assign cnt_x = {1'b0, cnt_q};
  assign ld_x  = {1'b0, load_val};

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    lim_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
      pre_d = '0;
    end else if (load) begin
      pre_d = '0;
      if (ld_x < MODV) cnt_d = load_val;
      else             cnt_d = MAXV[WIDTH-1:0];
    end else if (en) begin
      if (pre_q != PLAST) begin
        pre_d = pre_q + 1'b1;
      end else begin
        pre_d = '0;
        if (up) begin
          if (cnt_x == MAXV) begin
            lim_d = 1'b1;
            if (!SATURATE) cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          if (cnt_q == '0) begin
            lim_d = 1'b1;
            if (!SATURATE) cnt_d = MAXV[WIDTH-1:0];
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pre_q <= '0;
      lim_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      lim_q <= lim_d;
    end
  end

  assign count = cnt_q;
  assign limit = lim_q;

endmodule
